// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - ctrbus field indices, no-op encoding and FSM state type for the fetch stage
package fetch_pkg;

  localparam int CTRBUS_W     = 35;
  localparam int CTRBUS_VALID = 34;
  localparam int CTRBUS_BRCH  = 33;
  localparam int CTRBUS_KILL  = 32;

  localparam logic [31:0] INST_NOP = 32'h0;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Saturating 32-bit add used by the optional event counters
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO; flush wins over push/pop in the same cycle
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    do_push  = push & ~flush & ~full;
    do_pop   = pop & ~flush & ~empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with credit-limited imem requests; FETCH_PERF_EN adds event counters
module fetch_stage import fetch_pkg::*; #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter logic [31:0] PC_INC          = 32'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CTRBUS_W-1:0]  ctrbus,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_dropped
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [OW-1:0] occupancy;
  logic          redirect, req, accept, rsp, discard, push, pop;

  // Kill always accompanies brch, so it carries no extra meaning here
  logic unused_kill;
  assign unused_kill = ctrbus[CTRBUS_KILL];

  // BOOT spends exactly one clock after reset release before fetching starts
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Request credit, response accounting and redirect handling
  always_comb begin
    redirect  = ctrbus[CTRBUS_VALID] & ctrbus[CTRBUS_BRCH];
    occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Reserving a slot per in-flight request guarantees every kept response can be pushed
    req       = (state_q == RUN) & ~redirect
              & (outstanding_q < CW'(MAX_OUTSTANDING))
              & (occupancy < OW'(FIFO_DEPTH));
    accept    = req & imem_gnt;
    rsp       = imem_rvalid & (outstanding_q != '0);
    discard   = rsp & (redirect | (drop_cnt_q != '0));
    push      = rsp & ~discard & ~fifo_full;
    pop       = ctrbus[CTRBUS_VALID] & ~fifo_empty & ~redirect;

    pc_d = pc_q;
    if (redirect)    pc_d = ctrbus[31:0];
    else if (accept) pc_d = pc_q + PC_INC;

    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);

    // On redirect every response still in flight belongs to the old path
    drop_cnt_d = drop_cnt_q;
    if (redirect)                       drop_cnt_d = outstanding_q - CW'(rsp);
    else if (rsp && drop_cnt_q != '0)   drop_cnt_d = drop_cnt_q - CW'(1);
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign inst_valid = ~fifo_empty;
  assign inst       = fifo_empty ? INST_NOP : fifo_head;
  assign imem_req   = req;
  assign imem_addr  = pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  // Dropped covers stale responses plus valid entries thrown away by a flush
  always_comb begin
    perf_fetched_d = sat_add32(perf_fetched_q, {31'd0, push});
    perf_dropped_d = sat_add32(perf_dropped_q,
                               {31'd0, discard} + (redirect ? 32'(fifo_count) : 32'd0));
  end

  // Event counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a transaction-level model
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [34:0] GO     = 35'h4_0000_0000;
  localparam logic [34:0] HOLD   = 35'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [34:0] ctrbus = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ctrbus      (ctrbus),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          m_fifo = 0;
  int unsigned m_fetched = 0;
  int unsigned m_dropped = 0;
  bit          running = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  int          dly_lo = 0;
  int          dly_hi = 0;
  int          spur_pct = 0;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // One cycle: drive at negedge, observe 1ns later, update the model, cross the posedge
  task automatic step(input logic g, input logic [34:0] ctr);
    logic  rv, hs, redir, pop, exp_r;
    pend_t e;
    imem_gnt = g;
    ctrbus   = ctr;
    rv = (pend.size() > 0) && (pend[0].rdy <= cyc);
    imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    imem_rvalid = rv || (pend.size() == 0 && int'($urandom_range(99, 0)) < spur_pct);
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_inst = inst; obs_valid = inst_valid;
    redir = ctr[34] & ctr[33];
    exp_r = running && !redir && (pend.size() < MAXO) && (pend.size() + m_fifo < DEPTH);
    checks++;
    if (imem_req !== exp_r) begin
      errors++; $display("FAIL req cyc=%0d got %b expected %b", cyc, imem_req, exp_r);
    end
    checks++;
    if (inst_valid !== (m_fifo != 0)) begin
      errors++; $display("FAIL inst_valid cyc=%0d got %b expected %b", cyc, inst_valid, m_fifo != 0);
    end
    if (inst_valid === 1'b0) begin
      checks++;
      if (inst !== 32'h0) begin
        errors++; $display("FAIL nop cyc=%0d got %h expected 00000000", cyc, inst);
      end
    end
    hs = (imem_req === 1'b1) && g;
    if (hs) begin
      checks++;
      if (imem_addr !== exp_req) begin
        errors++; $display("FAIL req_addr cyc=%0d got %h expected %h", cyc, imem_addr, exp_req);
      end
    end
    pop = ctr[34] && (inst_valid === 1'b1) && !redir;
    if (pop) begin
      checks++;
      if (inst !== mem_word(exp_pc)) begin
        errors++; $display("FAIL inst cyc=%0d got %h expected %h (pc %h)", cyc, inst, mem_word(exp_pc), exp_pc);
      end
      exp_pc += 32'd1;
      pops++;
      if (m_fifo > 0) m_fifo--;
    end
    if (rv) begin
      e = pend.pop_front();
      if (e.stale || redir) m_dropped++;
      else begin m_fetched++; m_fifo++; end
    end
    if (hs) begin
      e.addr = exp_req; e.rdy = cyc + 1 + int'($urandom_range(dly_hi, dly_lo)); e.stale = 0;
      pend.push_back(e);
      exp_req += 32'd1;
    end
    if (redir) begin
      m_dropped += m_fifo; m_fifo = 0;
      foreach (pend[i]) pend[i].stale = 1;
      exp_pc = ctr[31:0]; exp_req = ctr[31:0];
    end
    @(posedge clk);
    cyc++;
    running = 1;
    @(negedge clk);
  endtask

  // Assert reset (checking outputs respond asynchronously), hold, release at a negedge
  task automatic do_reset(input int hold);
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; ctrbus = '0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL rst_inst got valid=%b inst=%h expected 0/00000000", inst_valid, inst);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL rst_req got req=%b addr=%h expected 0/%h", imem_req, imem_addr, RST_PC);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0) begin
      errors++; $display("FAIL rst_perf got %h/%h expected 0/0", perf_fetched, perf_dropped);
    end
`endif
    pend.delete(); m_fifo = 0; m_fetched = 0; m_dropped = 0;
    exp_pc = RST_PC; exp_req = RST_PC; running = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    spur_pct = 100;
    step(1'b1, GO);
    spur_pct = 0;
    checks++;
    if (obs_req !== 1'b0 || obs_addr !== RST_PC) begin
      errors++; $display("FAIL boot_cycle got req=%b addr=%h expected 0/%h", obs_req, obs_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset(2);
    dly_lo = 0; dly_hi = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, GO);
      checks++;
      if (obs_valid !== (i >= 3)) begin
        errors++; $display("FAIL seq_valid i=%0d got %b expected %b", i, obs_valid, i >= 3);
      end
      checks++;
      if (obs_req !== (i >= 1)) begin
        errors++; $display("FAIL seq_req i=%0d got %b expected %b", i, obs_req, i >= 1);
      end
    end
  endtask

  task automatic test_stall();
    int p0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, HOLD);
      checks++;
      if (obs_valid !== 1'b1 || obs_inst !== mem_word(exp_pc)) begin
        errors++; $display("FAIL stall_hold i=%0d got %b/%h expected 1/%h", i, obs_valid, obs_inst, mem_word(exp_pc));
      end
      if (i >= 2) begin
        checks++;
        if (obs_req !== 1'b0) begin
          errors++; $display("FAIL stall_full i=%0d got req=%b expected 0", i, obs_req);
        end
      end
    end
    p0 = pops;
    for (int i = 0; i < 8; i++) step(1'b1, GO);
    checks++;
    if (pops - p0 != 8) begin
      errors++; $display("FAIL stall_resume got %0d pops expected 8", pops - p0);
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    bit seen = 0;
    dly_lo = 2; dly_hi = 2;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2 && pend[0].rdy > cyc) found = 1;
      else step(1'b1, GO);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL redir_setup got no 2-outstanding window expected one within 20 cycles");
    end
    step(1'b1, 35'h6_0000_0040);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++; $display("FAIL redir_noreq got %b expected 0", obs_req);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b1, GO);
      if (obs_valid === 1'b1 && !seen) begin
        seen = 1;
        checks++;
        if (obs_inst !== mem_word(32'h40)) begin
          errors++; $display("FAIL redir_first got %h expected %h", obs_inst, mem_word(32'h40));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL redir_resume got no valid inst expected one within 15 cycles");
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 0;
    dly_lo = 1; dly_hi = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].rdy <= cyc) found = 1;
      else step(1'b1, GO);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rvredir_setup got no rvalid window expected one within 20 cycles");
    end
    step(1'b1, 35'h7_0000_0300);
    step(1'b1, 35'h7_FFFF_FFFE);
    for (int i = 0; i < 15; i++) step(1'b1, GO);
    checks++;
    if (exp_pc - 32'hFFFF_FFFE < 32'd3) begin
      errors++; $display("FAIL pc_wrap got next pc %h expected beyond 00000000", exp_pc);
    end
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    dly_lo = 0; dly_hi = 0;
    for (int i = 0; i < 4; i++) step(1'b1, GO);
    a0 = exp_req;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, GO);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== a0) begin
        errors++; $display("FAIL gnt_hold i=%0d got %b/%h expected 1/%h", i, obs_req, obs_addr, a0);
      end
    end
    step(1'b1, GO);
    step(1'b0, GO);
    checks++;
    if (obs_addr !== a0 + 32'd1) begin
      errors++; $display("FAIL gnt_advance got %h expected %h", obs_addr, a0 + 32'd1);
    end
  endtask

  task automatic test_reset_midburst();
    bit found = 0;
    dly_lo = 3; dly_hi = 3;
    for (int i = 0; i < 3; i++) step(1'b1, HOLD);
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2 && m_fifo > 0) found = 1;
      else step(1'b1, HOLD);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midburst_setup got no busy window expected one within 20 cycles");
    end
    do_reset(2);
    dly_lo = 0; dly_hi = 1;
    for (int i = 0; i < 8; i++) step(1'b1, GO);
    checks++;
    if (exp_req == RST_PC) begin
      errors++; $display("FAIL midburst_restart got no fetch expected restart at %h", RST_PC);
    end
  endtask

  task automatic test_random();
    int          p0;
    logic        v, b, g;
    logic [31:0] tgt;
    dly_lo = 0; dly_hi = 3; spur_pct = 20;
    p0 = pops;
    for (int i = 0; i < 500; i++) begin
      g   = ($urandom_range(3, 0) != 0);
      v   = ($urandom_range(4, 0) != 0);
      b   = ($urandom_range(99, 0) < 5);
      tgt = ($urandom_range(1, 0) != 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
      step(g, {v, b, b, tgt});
    end
    spur_pct = 0;
    checks++;
    if (pops - p0 < 100) begin
      errors++; $display("FAIL rand_progress got %0d pops expected at least 100", pops - p0);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== m_fetched || perf_dropped !== m_dropped) begin
      errors++; $display("FAIL perf got %0d/%0d expected %0d/%0d", perf_fetched, perf_dropped, m_fetched, m_dropped);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_gnt_hold();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
